// File: rtl/clint_irq_ctrl.sv
// Machine-mode interrupt source: 64-bit mtime/mtimecmp timer, software
// interrupt bit and edge-latched external line behind a word-addressed
// register bus. Arbitrates pending sources into a held interrupt request
// with a frozen mcause value and follows the trap through trap_taken/mret.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no request outstanding; raise one when MIE and any eligible
// ST_REQ     | interrupt_o held high with irq_cause_o frozen until trap_taken
// ST_SERVICE | handler running; no new request until mret returns to IDLE
module clint_irq_ctrl #(
    parameter int unsigned TIMER_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,          // active-low, synchronous
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [3:0]  req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_ready_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    input  logic        ext_irq_in_i,
    input  logic        mie_global_i,
    input  logic        trap_taken_i,
    input  logic        mret_i,
    output logic        interrupt_o,
    output logic [31:0] irq_cause_o
);

    localparam int unsigned PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

    localparam logic [3:0] ADDR_MTIME_LO    = 4'd0;
    localparam logic [3:0] ADDR_MTIME_HI    = 4'd1;
    localparam logic [3:0] ADDR_MTIMECMP_LO = 4'd2;
    localparam logic [3:0] ADDR_MTIMECMP_HI = 4'd3;
    localparam logic [3:0] ADDR_MSIP        = 4'd4;
    localparam logic [3:0] ADDR_IE          = 4'd5;
    localparam logic [3:0] ADDR_IP          = 4'd6;
    localparam logic [3:0] ADDR_EXT_CLAIM   = 4'd7;

    localparam logic [31:0] CAUSE_SW    = 32'h8000_0003;
    localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;
    localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Registers
    logic [63:0]   mtime_q, mtime_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtimecmp_q;
    logic          msip_q;
    logic [2:0]    ie_q;
    logic          ext_pending_q;
    logic          sync1_q, sync2_q, sync3_q;
    logic          req_ready_q;
    logic          resp_valid_q;
    logic [31:0]   resp_rdata_q;
    state_t        state_q;
    logic          interrupt_q;
    logic [31:0]   irq_cause_q;

    // Decoded bus strobes and derived status
    logic        wr_en, rd_en;
    logic        wr_mtime_lo, wr_mtime_hi, wr_mtime;
    logic        wr_cmp_lo, wr_cmp_hi, wr_msip, wr_ie;
    logic        claim_rd;
    logic        tick;
    logic        ext_rise;
    logic        mtip;
    logic [2:0]  pending;
    logic [2:0]  eligible;
    logic [31:0] win_cause;
    logic [31:0] rdata;

    assign wr_en       = req_valid_i & req_we_i;
    assign rd_en       = req_valid_i & ~req_we_i;
    assign wr_mtime_lo = wr_en && (req_addr_i == ADDR_MTIME_LO);
    assign wr_mtime_hi = wr_en && (req_addr_i == ADDR_MTIME_HI);
    assign wr_mtime    = wr_mtime_lo | wr_mtime_hi;
    assign wr_cmp_lo   = wr_en && (req_addr_i == ADDR_MTIMECMP_LO);
    assign wr_cmp_hi   = wr_en && (req_addr_i == ADDR_MTIMECMP_HI);
    assign wr_msip     = wr_en && (req_addr_i == ADDR_MSIP);
    assign wr_ie       = wr_en && (req_addr_i == ADDR_IE);
    assign claim_rd    = rd_en && (req_addr_i == ADDR_EXT_CLAIM);

    assign tick     = (presc_q == PRESC_MAX);
    assign ext_rise = sync2_q & ~sync3_q;
    assign mtip     = (mtime_q >= mtimecmp_q);
    assign pending  = {ext_pending_q, mtip, msip_q};
    assign eligible = pending & ie_q;

    // Winning source cause: ext > SW > timer
    always_comb begin
        win_cause = 32'h0;
        if (eligible[2]) begin
            win_cause = CAUSE_EXT;
        end else if (eligible[0]) begin
            win_cause = CAUSE_SW;
        end else if (eligible[1]) begin
            win_cause = CAUSE_TIMER;
        end
    end

    // Read data mux; a claim racing a new edge still reports the edge
    always_comb begin
        rdata = 32'h0;
        case (req_addr_i)
            ADDR_MTIME_LO:    rdata = mtime_q[31:0];
            ADDR_MTIME_HI:    rdata = mtime_q[63:32];
            ADDR_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
            ADDR_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
            ADDR_MSIP:        rdata = {31'h0, msip_q};
            ADDR_IE:          rdata = {29'h0, ie_q};
            ADDR_IP:          rdata = {29'h0, pending};
            ADDR_EXT_CLAIM:   rdata = {31'h0, ext_pending_q | ext_rise};
            default:          rdata = 32'h0;
        endcase
    end

    // Timer next state: a software write to mtime beats the increment
    always_comb begin
        mtime_d = mtime_q;
        presc_d = presc_q;
        if (wr_mtime) begin
            presc_d = '0;
            if (wr_mtime_lo) begin
                mtime_d[31:0] = req_wdata_i;
            end else begin
                mtime_d[63:32] = req_wdata_i;
            end
        end else if (tick) begin
            presc_d = '0;
            mtime_d = mtime_q + 64'd1;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Timer registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mtime_q <= 64'h0;
            presc_q <= '0;
        end else begin
            mtime_q <= mtime_d;
            presc_q <= presc_d;
        end
    end

    // Software-visible configuration registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q     <= 1'b0;
            ie_q       <= 3'b000;
        end else begin
            if (wr_cmp_lo) begin
                mtimecmp_q[31:0] <= req_wdata_i;
            end
            if (wr_cmp_hi) begin
                mtimecmp_q[63:32] <= req_wdata_i;
            end
            if (wr_msip) begin
                msip_q <= req_wdata_i[0];
            end
            if (wr_ie) begin
                ie_q <= req_wdata_i[2:0];
            end
        end
    end

    // External line synchronizer plus previous-value flop for edge detect
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= ext_irq_in_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // External pending latch; a fresh edge outranks a claim
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ext_pending_q <= 1'b0;
        end else if (ext_rise) begin
            ext_pending_q <= 1'b1;
        end else if (claim_rd) begin
            ext_pending_q <= 1'b0;
        end
    end

    // Bus response: one-cycle pulse, write responses carry zero data
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            req_ready_q  <= 1'b1;
            resp_valid_q <= req_valid_i;
            resp_rdata_q <= rd_en ? rdata : 32'h0;
        end
    end

    // Request/service state machine with registered interrupt and cause
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            interrupt_q <= 1'b0;
            irq_cause_q <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mie_global_i && (eligible != 3'b000)) begin
                        state_q     <= ST_REQ;
                        interrupt_q <= 1'b1;
                        irq_cause_q <= win_cause;
                    end
                end
                ST_REQ: begin
                    if (trap_taken_i) begin
                        state_q     <= ST_SERVICE;
                        interrupt_q <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (mret_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    interrupt_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign interrupt_o  = interrupt_q;
    assign irq_cause_o  = irq_cause_q;

endmodule
